// File: rtl/mux_arbiter_2x1_pkg.sv
// Shared types and defaults for the two-requester grant arbiter.
// The state encoding is fixed so that waveforms and any external decoders see stable codes.
package mux_arbiter_2x1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } arb_state_e;

    localparam int MAX_HOLD_DEFAULT = 15;
    localparam int HOLD_CNT_W       = 8;

endpackage

// File: rtl/mux_arbiter_2x1_if.sv
// Request/grant/data bundle between two requesters and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface mux_arbiter_2x1_if #(
    parameter int WIDTH = 8
);
    logic             req_a;
    logic             req_b;
    logic             done_a;
    logic             done_b;
    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] din_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;

    modport master (
        output req_a, req_b, done_a, done_b, din_a, din_b,
        input  gnt_a, gnt_b, sel, dout, dout_valid, busy
    );

    modport slave (
        input  req_a, req_b, done_a, done_b, din_a, din_b,
        output gnt_a, gnt_b, sel, dout, dout_valid, busy
    );
endinterface

// File: rtl/mux_arbiter_2x1_mux2_w.sv
// WIDTH-bit 2:1 data multiplexer; in1 is chosen when sel is high.
module mux2_w #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_arbiter_2x1.sv
// Two-requester arbiter with round-robin tie-break, bounded hold time and a registered data select.
// Grants, select and busy are all flops so downstream logic sees glitch-free control.
module mux_arbiter_2x1
    import mux_arbiter_2x1_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_arbiter_2x1_if.slave      bus
);

    // MAX_HOLD is legal from 2 to 255, so the last hold value always fits the counter.
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

    arb_state_e            state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                  last_b_q, last_b_d;
    logic                  sel_q, sel_d;
    logic                  gnt_a_q, gnt_a_d;
    logic                  gnt_b_q, gnt_b_d;
    logic                  busy_q, busy_d;
    logic                  release_a;
    logic                  release_b;
    logic [HOLD_CNT_W-1:0] hold_next;

    assign release_a = !bus.req_a || bus.done_a || ((hold_cnt_q == HOLD_LAST) && bus.req_b);
    assign release_b = !bus.req_b || bus.done_b || ((hold_cnt_q == HOLD_LAST) && bus.req_a);
    assign hold_next = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_b_d   = last_b_q;
        sel_d      = sel_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_b_q)) begin
                    state_d    = GNT_A;
                    hold_cnt_d = '0;
                    last_b_d   = 1'b0;
                    sel_d      = 1'b0;
                end else if (bus.req_b) begin
                    state_d    = GNT_B;
                    hold_cnt_d = '0;
                    last_b_d   = 1'b1;
                    sel_d      = 1'b1;
                end
            end
            GNT_A: begin
                if (!release_a) begin
                    hold_cnt_d = hold_next;
                end else if (bus.req_b) begin
                    state_d    = GNT_B;
                    hold_cnt_d = '0;
                    last_b_d   = 1'b1;
                    sel_d      = 1'b1;
                end else if (bus.req_a) begin
                    // Finished a burst with nobody else waiting: keep the grant, restart the hold window.
                    hold_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_B: begin
                if (!release_b) begin
                    hold_cnt_d = hold_next;
                end else if (bus.req_a) begin
                    state_d    = GNT_A;
                    hold_cnt_d = '0;
                    last_b_d   = 1'b0;
                    sel_d      = 1'b0;
                end else if (bus.req_b) begin
                    hold_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_a_d = (state_d == GNT_A);
        gnt_b_d = (state_d == GNT_B);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            last_b_q   <= 1'b1;
            sel_q      <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_b_q   <= last_b_d;
            sel_q      <= sel_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.gnt_a      = gnt_a_q;
    assign bus.gnt_b      = gnt_b_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = busy_q;
    assign bus.dout_valid = (gnt_a_q & bus.req_a) | (gnt_b_q & bus.req_b);

    mux2_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (sel_q),
        .in0 (bus.din_a),
        .in1 (bus.din_b),
        .out (bus.dout)
    );

endmodule

// File: doc/mux_arbiter_2x1.md
MUX_ARBITER_2X1 -- requirements
Module: mux_arbiter_2x1

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester path and of dout.
REQ-002 Parameter MAX_HOLD, default 15: maximum consecutive grant cycles while the other side waits; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_a, req_b  input  1 each  request from requester A and requester B.
REQ-006 done_a, done_b  input  1 each  last-beat marker from the granted requester; ignored unless that requester is granted.
REQ-007 din_a, din_b  input  WIDTH each  requester data.
REQ-008 gnt_a, gnt_b  output  1 each  registered grant; never both high.
REQ-009 sel  output  1  registered mux select; 0 selects A, 1 selects B.
REQ-010 dout  output  WIDTH  equals din_b when sel=1, else din_a (combinational from sel).
REQ-011 dout_valid  output  1  (gnt_a & req_a) | (gnt_b & req_b).
REQ-012 busy  output  1  high in any grant state.

Function
REQ-013 The FSM has three states: IDLE, GNT_A, GNT_B; gnt_a=1 only in GNT_A, gnt_b=1 only in GNT_B.
REQ-014 A 1-bit pointer last_b records the most recently granted side (1=B); it updates on every grant entry.
REQ-015 IDLE with one requester: enter that side's grant state on the next edge (1-cycle request-to-grant latency).
REQ-016 IDLE with both requesting: grant A if last_b=1, else grant B.
REQ-017 Release condition for the granted side X: req_X=0, or done_X=1, or (hold_cnt=MAX_HOLD-1 and the other side is requesting).
REQ-018 On release, if the other side is requesting, switch directly to its grant state on the next edge (no idle bubble); otherwise go to IDLE.
REQ-019 On release via done_X with req_X still high and the other side idle, stay in the same grant state and reset hold_cnt to 0.
REQ-020 hold_cnt (8 bits) resets to 0 on every grant entry and increments each grant cycle; it saturates at MAX_HOLD-1 when the other side is not requesting, so the grant continues.
REQ-021 sel is set on grant entry (A:0, B:1) and holds its last value in IDLE.
REQ-022 A requester dropping req in the same cycle the other raises req follows REQ-018 (direct switch).

Reset
REQ-023 While rst_n=0 at a clock edge: state=IDLE, gnt_a=gnt_b=0, sel=0, last_b=1, hold_cnt=0, busy=0.
REQ-024 A reset asserted mid-grant aborts the transfer at that edge; no grant is held after reset.

Structure
REQ-025 The shared package holds the state encoding (IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10) and the MAX_HOLD default.
REQ-026 The data path is one instance of a parameterised sub-module mux2_w (WIDTH-bit 2:1 mux); the FSM, pointer and counter stay in mux_arbiter_2x1.

Verification
REQ-027 Reset: drive rst_n=0 for 2 cycles with req_a=req_b=1 -> gnt_a=gnt_b=0, sel=0, busy=0; after release, gnt_a=1 one cycle later.
REQ-028 Single requester: req_b=1 from IDLE, din_b=8'hA5 -> next cycle gnt_b=1, sel=1, dout=8'hA5, dout_valid=1.
REQ-029 Fairness: both requesters held high with done pulsed every 3 grant cycles -> grants alternate A,B,A,B with no IDLE cycle between them.
REQ-030 Timeout: A held without done while B requests -> gnt_a high for exactly 15 cycles, then gnt_b=1 on the next edge.
REQ-031 Saturation: A requests alone for 40 cycles -> gnt_a continuous; req_b then rises -> B is granted after at most 15 further cycles... (counter already saturated: B is granted on the next edge).
REQ-032 Mid-operation reset: rst_n=0 during GNT_B -> next edge IDLE, last_b=1, and with both requesting A is granted first.
